// File: rtl/fifo_write_arbiter_pkg.sv
// ============================================================================
// Module  : fifo_write_arbiter_pkg
// Purpose : Shared state encodings, default watermarks and sizing helpers
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_write_arbiter_pkg;

    localparam logic [0:0] ST_ACCEPT   = 1'b0;
    localparam logic [0:0] ST_THROTTLE = 1'b1;

    localparam int c_DEF_HIGH_WM = 5;
    localparam int c_DEF_LOW_WM  = 2;

    // Index width that stays legal (>=1 bit) for single-entry vectors.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_pick.sv
// ============================================================================
// Module  : fifo_write_arbiter_rr_pick
// Purpose : Combinational rotate-priority encoder starting at i_start
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_write_arbiter_rr_pick
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [N-1:0]     o_pick,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int w_j;

    always_comb begin
        o_pick = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_j    = 0;
        for (int s = 0; s < N; s++) begin
            w_j = (int'(i_start) + s) % N;
            if (!o_any && i_req[IDX_W'(w_j)]) begin
                o_any  = 1'b1;
                o_idx  = IDX_W'(w_j);
                o_pick = N'(1) << w_j;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
// ============================================================================
// Module  : fifo_write_arbiter
// Purpose : Round-robin, burst-limited, watermark-throttled FIFO write arbiter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 4,
    parameter int HIGH_WM   = c_DEF_HIGH_WM,
    parameter int LOW_WM    = c_DEF_LOW_WM,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    output logic [N_REQ-1:0]        o_gnt,
    output logic                    o_wr_en,
    output logic [DATA_W-1:0]       o_fifo_data,
    input  logic [CNT_W-1:0]        i_fifo_words,
    input  logic                    i_fifo_full,
    output logic                    o_throttled
);

    localparam int IDX_W = idx_w(N_REQ);
    localparam int BC_W  = $clog2(MAX_BURST) + 1;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_last_win;
    logic [BC_W-1:0]  r_burst_cnt;

    logic [IDX_W-1:0] w_start;
    logic [N_REQ-1:0] w_pick;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_any;
    logic             w_en;
    logic             w_cont;
    logic [IDX_W-1:0] w_win;

    assign w_start = (r_last_win == IDX_W'(N_REQ - 1)) ? '0 : r_last_win + 1'b1;

    fifo_write_arbiter_rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_start (w_start),
        .o_pick  (w_pick),
        .o_idx   (w_pick_idx),
        .o_any   (w_any)
    );

    // rst gating kills a grant combinationally the instant reset asserts.
    assign w_en = !rst && (r_state == ST_ACCEPT) && (i_fifo_words < CNT_W'(HIGH_WM))
                  && !i_fifo_full && w_any;

    assign w_cont = i_req[r_last_win] && (r_burst_cnt != '0)
                    && (r_burst_cnt < BC_W'(MAX_BURST));

    assign w_win       = w_cont ? r_last_win : w_pick_idx;
    assign o_gnt       = !w_en ? '0 : (w_cont ? (N_REQ'(1) << r_last_win) : w_pick);
    assign o_wr_en     = w_en;
    assign o_fifo_data = w_en ? i_req_data[w_win*DATA_W +: DATA_W] : '0;
    assign o_throttled = !rst && (r_state == ST_THROTTLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCEPT;
        end else begin
            case (r_state)
                ST_ACCEPT:   if (i_fifo_words >= CNT_W'(HIGH_WM)) r_state <= ST_THROTTLE;
                ST_THROTTLE: if (i_fifo_words <= CNT_W'(LOW_WM))  r_state <= ST_ACCEPT;
                default:     r_state <= ST_ACCEPT;
            endcase
        end
    end

    // A search-path regrant (even to the same producer) starts a fresh burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_win  <= IDX_W'(N_REQ - 1);
            r_burst_cnt <= '0;
        end else if (w_en) begin
            r_last_win  <= w_win;
            r_burst_cnt <= w_cont ? r_burst_cnt + 1'b1 : BC_W'(1);
        end else begin
            r_burst_cnt <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// ============================================================================
// Module  : tb_fifo_write_arbiter
// Purpose : Scoreboard bench for fifo_write_arbiter (MAX_BURST=4 and =1)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  fifo_words = '0;
    logic        fifo_full = 1'b0;

    logic [3:0] gnt4, gnt1;
    logic       wr4, wr1, thr4, thr1;
    logic [7:0] dat4, dat1;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.MAX_BURST(4)) dut4 (
        .clk(clk), .rst(rst), .i_req(req), .i_req_data(req_data),
        .o_gnt(gnt4), .o_wr_en(wr4), .o_fifo_data(dat4),
        .i_fifo_words(fifo_words), .i_fifo_full(fifo_full), .o_throttled(thr4)
    );

    fifo_write_arbiter #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .i_req(req), .i_req_data(req_data),
        .o_gnt(gnt1), .o_wr_en(wr1), .o_fifo_data(dat1),
        .i_fifo_words(fifo_words), .i_fifo_full(fifo_full), .o_throttled(thr1)
    );

    typedef struct packed {
        logic [1:0][3:0] g;
        logic [1:0]      w;
        logic [1:0][7:0] d;
        logic [1:0]      t;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int   m_last [2];
    int   m_cnt  [2];
    bit   m_thr  [2];
    int   MB     [2] = '{4, 1};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req_v);
        n_tests++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 3;
            m_cnt[k]  = 0;
            m_thr[k]  = 1'b0;
        end
    endtask

    // One clock of stimulus; the expected outputs for this cycle are queued.
    task automatic drive(input logic a_rst, input logic [3:0] a_req, input logic [3:0] a_words,
                         input logic a_full, input logic [31:0] a_data);
        exp_t e;
        int   w;
        bit   en, cont;
        @(posedge clk);
        #1;
        rst = a_rst; req = a_req; fifo_words = a_words; fifo_full = a_full; req_data = a_data;
        e = '0;
        if (a_rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                e.t[k] = m_thr[k];
                en = !m_thr[k] && (a_words < 5) && !a_full && (a_req != 0);
                if (en) begin
                    cont = (m_cnt[k] > 0) && (m_cnt[k] < MB[k]) && a_req[m_last[k]];
                    w = -1;
                    if (cont) w = m_last[k];
                    else
                        for (int s = 1; s <= 4; s++)
                            if (w < 0 && a_req[(m_last[k] + s) % 4]) w = (m_last[k] + s) % 4;
                    e.g[k][w] = 1'b1;
                    e.w[k]    = 1'b1;
                    e.d[k]    = a_data[w*8 +: 8];
                    m_cnt[k]  = cont ? m_cnt[k] + 1 : 1;
                    m_last[k] = w;
                end else begin
                    m_cnt[k] = 0;
                end
                if (!m_thr[k] && a_words >= 5) m_thr[k] = 1'b1;
                else if (m_thr[k] && a_words <= 2) m_thr[k] = 1'b0;
            end
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("gnt_mb4",  {4'h0, gnt4}, {4'h0, e.g[0]});
            check("wr_mb4",   {7'h0, wr4},  {7'h0, e.w[0]});
            check("data_mb4", dat4,         e.d[0]);
            check("thr_mb4",  {7'h0, thr4}, {7'h0, e.t[0]});
            check("gnt_mb1",  {4'h0, gnt1}, {4'h0, e.g[1]});
            check("wr_mb1",   {7'h0, wr1},  {7'h0, e.w[1]});
            check("data_mb1", dat1,         e.d[1]);
            check("thr_mb1",  {7'h0, thr1}, {7'h0, e.t[1]});
        end
    end

    initial begin
        int occ, nw;
        model_reset();

        // Reset with all producers requesting, then release.
        repeat (3) drive(1'b1, 4'b1111, 4'd0, 1'b0, 32'h44332211);
        #1;
        check("rst_gnt", {4'h0, gnt4}, 8'h00);
        check("rst_thr", {7'h0, thr4}, 8'h00);
        repeat (10) drive(1'b0, 4'b1111, 4'd0, 1'b0, 32'h44332211);

        // Two producers bursting, then req0 drops mid-burst.
        repeat (2) drive(1'b1, 4'b0011, 4'd0, 1'b0, 32'h0);
        repeat (10) drive(1'b0, 4'b0011, 4'd0, 1'b0, 32'h0000BBAA);
        repeat (2) drive(1'b1, 4'b0011, 4'd0, 1'b0, 32'h0);
        repeat (2) drive(1'b0, 4'b0011, 4'd0, 1'b0, 32'h0000BBAA);
        repeat (3) drive(1'b0, 4'b0010, 4'd0, 1'b0, 32'h0000BBAA);

        // Hysteresis against a FIFO occupancy model with no reads.
        drive(1'b1, 4'b0001, 4'd0, 1'b0, 32'h0);
        occ = 0; nw = 0;
        repeat (10) begin
            drive(1'b0, 4'b0001, 4'(occ), occ >= 8, 32'h000000C3);
            #1;
            if (wr4) begin occ++; nw++; end
        end
        check("hyst_writes", 8'(nw), 8'd5);
        check("hyst_thr", {7'h0, thr4}, 8'h01);
        occ = 3; nw = 0;
        repeat (4) begin
            drive(1'b0, 4'b0001, 4'(occ), 1'b0, 32'h000000C3);
            #1;
            if (wr4) nw++;
        end
        check("drain3_writes", 8'(nw), 8'd0);
        occ = 2; nw = 0;
        repeat (3) begin
            drive(1'b0, 4'b0001, 4'(occ), 1'b0, 32'h000000C3);
            #1;
            if (wr4) begin occ++; nw++; end
        end
        check("resume_writes", 8'(nw), 8'd2);

        // Full guard in ACCEPT, then release.
        drive(1'b1, 4'b0000, 4'd0, 1'b0, 32'h0);
        repeat (3) drive(1'b0, 4'b1111, 4'd0, 1'b1, 32'h55667788);
        drive(1'b0, 4'b1111, 4'd0, 1'b0, 32'h55667788);

        // Async reset landing between edges while gnt=0010.
        drive(1'b1, 4'b0000, 4'd0, 1'b0, 32'h0);
        drive(1'b0, 4'b0011, 4'd0, 1'b0, 32'h00005A00);
        drive(1'b0, 4'b0010, 4'd0, 1'b0, 32'h00005A00);
        #1;
        check("pre_async_gnt", {4'h0, gnt4}, 8'h02);
        rst = 1'b1;
        #1;
        check("async_gnt4", {4'h0, gnt4}, 8'h00);
        check("async_wr4",  {7'h0, wr4},  8'h00);
        check("async_gnt1", {4'h0, gnt1}, 8'h00);
        q[q.size()-1] = '0;
        model_reset();
        drive(1'b1, 4'b0110, 4'd0, 1'b0, 32'h0);
        repeat (4) drive(1'b0, 4'b0110, 4'd0, 1'b0, 32'h00776600);

        // Randomized traffic with occasional resets.
        repeat (600) begin
            drive(($urandom_range(0, 49) == 0), 4'($urandom), 4'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0), $urandom);
        end

        @(negedge clk);
        #1;
        check("queue_drained", 8'(q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
